// File: rtl/mgmt_sram_arbiter.sv
// Round-robin arbiter between the management Wishbone slave port and a housekeeping
// read-only port, driving RAM_BLOCKS single-port SRAM banks with out-of-range error termination.
module mgmt_sram_arbiter #(
  parameter int          RAM_BLOCKS = 2,
  parameter int          ADDR_W     = 8,
  parameter int          RD_LAT     = 1,
  parameter logic [31:0] BASE_ADR   = 32'h0100_0000,
  localparam int         BW         = (RAM_BLOCKS > 1) ? $clog2(RAM_BLOCKS) : 1
) (
  input  logic                      core_clk,
  input  logic                      core_rst,
  input  logic                      wb_cyc_i,
  input  logic                      wb_stb_i,
  input  logic                      wb_we_i,
  input  logic [3:0]                wb_sel_i,
  input  logic [31:0]               wb_adr_i,
  input  logic [31:0]               wb_dat_i,
  output logic [31:0]               wb_dat_o,
  output logic                      wb_ack_o,
  output logic                      wb_err_o,
  input  logic                      hk_req_i,
  input  logic [ADDR_W+BW-1:0]      hk_addr_i,
  output logic [31:0]               hk_rdata_o,
  output logic                      hk_valid_o,
  output logic [RAM_BLOCKS-1:0]     ram_ena,
  output logic [RAM_BLOCKS-1:0]     ram_wen,
  output logic [4*RAM_BLOCKS-1:0]   ram_wen_mask,
  output logic [ADDR_W-1:0]         ram_addr,
  output logic [31:0]               ram_wdata,
  input  logic [32*RAM_BLOCKS-1:0]  ram_rdata
);

  localparam int CNT_W = 3;
  localparam int MASK_W = 4 * RAM_BLOCKS;
  localparam logic [31:0] SPAN = 32'(RAM_BLOCKS) << (ADDR_W + 2);
  localparam logic [CNT_W-1:0] WAIT_INIT = CNT_W'((RD_LAT > 1) ? RD_LAT - 2 : 0);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} arbState_t;

  arbState_t        r_state;
  logic             r_prioHk;
  logic             r_isHk;
  logic             r_we;
  logic             r_wbDrop;
  logic [BW-1:0]    r_bank;
  logic [CNT_W-1:0] r_cnt;

  logic              w_wbPend;
  logic              w_grantHk;
  logic              w_grantWb;
  logic              w_wbInRange;
  logic              w_hkInRange;
  logic              w_finish;
  logic              w_abort;
  logic [31:0]       w_wbOffset;
  logic [31:0]       w_rdWord;
  logic [BW-1:0]     w_wbBank;
  logic [BW-1:0]     w_hkBank;
  logic [ADDR_W-1:0] w_wbWord;
  logic [ADDR_W-1:0] w_hkWord;

  // r_prioHk set means HK wins the next tie; cleared on reset so WB goes first.
  assign w_wbPend  = wb_cyc_i & wb_stb_i;
  assign w_grantHk = hk_req_i & (~w_wbPend | r_prioHk);
  assign w_grantWb = w_wbPend & ~w_grantHk;

  assign w_wbOffset  = wb_adr_i - BASE_ADR;
  assign w_wbInRange = w_wbOffset < SPAN;
  assign w_wbWord    = wb_adr_i[2 +: ADDR_W];
  assign w_wbBank    = wb_adr_i[2+ADDR_W +: BW];
  assign w_hkWord    = hk_addr_i[0 +: ADDR_W];
  assign w_hkBank    = hk_addr_i[ADDR_W +: BW];
  assign w_hkInRange = 32'(w_hkBank) < 32'(RAM_BLOCKS);

  assign w_rdWord = ram_rdata[{r_bank, 5'b0} +: 32];
  assign w_finish = (r_state == S_ISSUE && (r_we || RD_LAT == 1)) ||
                    (r_state == S_WAIT && r_cnt == '0);
  assign w_abort  = ~r_isHk & (r_wbDrop | ~wb_cyc_i);

  always_ff @(posedge core_clk) begin
    if (core_rst) begin
      r_state      <= S_IDLE;
      r_prioHk     <= 1'b0;
      r_isHk       <= 1'b0;
      r_we         <= 1'b0;
      r_wbDrop     <= 1'b0;
      r_bank       <= '0;
      r_cnt        <= '0;
      wb_dat_o     <= '0;
      wb_ack_o     <= 1'b0;
      wb_err_o     <= 1'b0;
      hk_rdata_o   <= '0;
      hk_valid_o   <= 1'b0;
      ram_ena      <= '0;
      ram_wen      <= '0;
      ram_wen_mask <= '0;
      ram_addr     <= '0;
      ram_wdata    <= '0;
    end else begin
      wb_ack_o     <= 1'b0;
      wb_err_o     <= 1'b0;
      hk_valid_o   <= 1'b0;
      ram_ena      <= '0;
      ram_wen      <= '0;
      ram_wen_mask <= '0;
      case (r_state)
        S_IDLE: begin
          r_wbDrop <= 1'b0;
          if (w_grantHk) begin
            r_prioHk <= 1'b0;
            r_isHk   <= 1'b1;
            r_we     <= 1'b0;
            r_bank   <= w_hkBank;
            ram_addr <= w_hkWord;
            if (w_hkInRange) begin
              ram_ena <= RAM_BLOCKS'(1) << w_hkBank;
              r_state <= S_ISSUE;
            end else begin
              hk_valid_o <= 1'b1;
              hk_rdata_o <= '0;
              r_state    <= S_RESP;
            end
          end else if (w_grantWb) begin
            r_prioHk <= 1'b1;
            r_isHk   <= 1'b0;
            r_we     <= wb_we_i;
            r_bank   <= w_wbBank;
            if (w_wbInRange) begin
              ram_addr  <= w_wbWord;
              ram_wdata <= wb_dat_i;
              ram_ena   <= RAM_BLOCKS'(1) << w_wbBank;
              if (wb_we_i) begin
                ram_wen      <= RAM_BLOCKS'(1) << w_wbBank;
                ram_wen_mask <= MASK_W'(wb_sel_i) << {w_wbBank, 2'b00};
              end
              r_state <= S_ISSUE;
            end else begin
              wb_err_o <= 1'b1;
              wb_dat_o <= '0;
              r_state  <= S_RESP;
            end
          end
        end
        // An abandoned WB cycle still lets the SRAM access finish; only the response is dropped.
        S_ISSUE, S_WAIT: begin
          if (~r_isHk & ~wb_cyc_i) r_wbDrop <= 1'b1;
          if (w_finish) begin
            r_state <= S_RESP;
            if (r_isHk) begin
              hk_valid_o <= 1'b1;
              hk_rdata_o <= w_rdWord;
            end else if (!w_abort) begin
              wb_ack_o <= 1'b1;
              wb_dat_o <= r_we ? 32'h0 : w_rdWord;
            end
          end else if (r_state == S_ISSUE) begin
            r_state <= S_WAIT;
            r_cnt   <= WAIT_INIT;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        S_RESP:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
